smoldvi_stream_gearbox: RTL and testbench

Single-clock, multi-lane width converter with valid/ready on both sides and arbitrary, non-integer input/output width ratios. It sits between the TMDS encoders and the serialiser/PHY wrapper and repacks N_CH lanes of W_IN-bit symbols into W_OUT-bit chunks, or the reverse. Unlike our fixed-ratio, free-running CDC gearbox, it applies backpressure, tracks fill level, and can optionally slip one bit for lane alignment. All lanes share one handshake and one fill level, so they stay in lockstep.

---
 rtl/smoldvi_stream_gearbox.sv | 145 ++++++++++++++
 tb/tb_smoldvi_stream_gearbox.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smoldvi_stream_gearbox.sv
// smoldvi_stream_gearbox: multi-lane valid/ready width converter (W_IN -> W_OUT bits
// per lane, any ratio). All lanes share one handshake and one fill level.
// Optional feature: define SMOLDVI_GEARBOX_BITSLIP_EN to add the bitslip port, which
// drops the oldest bit of every lane for alignment.

// Per-lane shift buffer. The shared control decides push/pop/slip and the write
// position; this block only moves bits.
module smoldvi_stream_gearbox_lane #(
  parameter int W_IN         = 10,
  parameter int W_OUT        = 2,
  parameter int STORAGE_SIZE = 24,
  parameter int LW           = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   in_word,
  input  logic              push,
  input  logic              pop,
  input  logic              slip,
  input  logic [LW-1:0]     wpos,
  output logic [W_OUT-1:0]  out_word
);
  logic [STORAGE_SIZE-1:0] buf_q;
  logic [STORAGE_SIZE-1:0] buf_d;
  logic [STORAGE_SIZE-1:0] shifted;
  logic [STORAGE_SIZE-1:0] ins;
  logic [STORAGE_SIZE-1:0] mask;

  // Retire the consumed bits first, then drop the new word in right above the
  // remaining valid bits, so push+pop matches pop followed by push.
  always_comb begin
    shifted = buf_q;
    if (pop)
      shifted = buf_q >> W_OUT;
    else if (slip)
      shifted = buf_q >> 1;
    ins   = STORAGE_SIZE'(in_word) << wpos;
    mask  = STORAGE_SIZE'({W_IN{1'b1}}) << wpos;
    buf_d = shifted;
    if (push)
      buf_d = (shifted & ~mask) | (ins & mask);
  end

  // Buffer register; reset clears it so out_data reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst)
      buf_q <= '0;
    else
      buf_q <= buf_d;
  end

  // Oldest bits sit at the bottom and leave straight from flops.
  assign out_word = buf_q[W_OUT-1:0];
endmodule

module smoldvi_stream_gearbox #(
  parameter int W_IN         = 10,
  parameter int W_OUT        = 2,
  parameter int N_CH         = 3,
  parameter int STORAGE_SIZE = 2*(W_IN+W_OUT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_CH*W_IN-1:0]                  in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [N_CH*W_OUT-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
`ifdef SMOLDVI_GEARBOX_BITSLIP_EN
  input  logic                                  bitslip,
`endif
  output logic [$clog2(STORAGE_SIZE+1)-1:0]     level
);
  localparam int LW = $clog2(STORAGE_SIZE+1);

  // A full word plus a full output chunk must fit, otherwise the block can deadlock.
  generate
    if (STORAGE_SIZE < W_IN + W_OUT) begin : g_size_chk
      $error("smoldvi_stream_gearbox: STORAGE_SIZE must be >= W_IN+W_OUT");
    end
  endgenerate

  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [LW-1:0] wpos;
  logic          push;
  logic          pop;
  logic          slip_act;

`ifdef SMOLDVI_GEARBOX_BITSLIP_EN
  // A slip on an empty buffer has nothing to discard and is ignored.
  assign slip_act = bitslip && (level_q != '0);
`else
  assign slip_act = 1'b0;
`endif

  // Ready and valid come only from the registered level (no out_ready -> in_ready path).
  assign in_ready  = (level_q <= LW'(STORAGE_SIZE - W_IN)) && !rst;
  assign out_valid = (level_q >= LW'(W_OUT)) && !slip_act;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Write position is the level after this cycle's removal; new level adds the push.
  always_comb begin
    wpos = level_q;
    if (pop)
      wpos = level_q - LW'(W_OUT);
    else if (slip_act)
      wpos = level_q - LW'(1);
    level_d = wpos;
    if (push)
      level_d = wpos + LW'(W_IN);
  end

  // Shared fill level; reset drops every buffered bit on the same edge.
  always_ff @(posedge clk) begin
    if (rst)
      level_q <= '0;
    else
      level_q <= level_d;
  end

  assign level = level_q;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_lane
      smoldvi_stream_gearbox_lane #(
        .W_IN         (W_IN),
        .W_OUT        (W_OUT),
        .STORAGE_SIZE (STORAGE_SIZE),
        .LW           (LW)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .in_word  (in_data[k*W_IN +: W_IN]),
        .push     (push),
        .pop      (pop),
        .slip     (slip_act),
        .wpos     (wpos),
        .out_word (out_data[k*W_OUT +: W_OUT])
      );
    end
  endgenerate
endmodule

// File: tb/tb_smoldvi_stream_gearbox.sv
// Directed bench for smoldvi_stream_gearbox: 10->2 x3 lanes, 2->10 and 10->4 single lane.
module tb_smoldvi_stream_gearbox;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  // instance A: default 10 -> 2, 3 lanes, storage 24
  logic [29:0] a_in;
  logic        a_iv, a_ir, a_ov, a_or, a_bs;
  logic [5:0]  a_od;
  logic [4:0]  a_lv;
  // instance B: 2 -> 10, 1 lane, storage 24
  logic [1:0]  b_in;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [9:0]  b_od;
  logic [4:0]  b_lv;
  // instance C: 10 -> 4, 1 lane, storage 28
  logic [9:0]  c_in;
  logic        c_iv, c_ir, c_ov, c_or;
  logic [3:0]  c_od;
  logic [4:0]  c_lv;

  smoldvi_stream_gearbox #(.W_IN(10), .W_OUT(2), .N_CH(3)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in), .in_valid(a_iv), .in_ready(a_ir),
    .out_data(a_od), .out_valid(a_ov), .out_ready(a_or),
`ifdef SMOLDVI_GEARBOX_BITSLIP_EN
    .bitslip(a_bs),
`endif
    .level(a_lv));

  smoldvi_stream_gearbox #(.W_IN(2), .W_OUT(10), .N_CH(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in), .in_valid(b_iv), .in_ready(b_ir),
    .out_data(b_od), .out_valid(b_ov), .out_ready(b_or),
`ifdef SMOLDVI_GEARBOX_BITSLIP_EN
    .bitslip(1'b0),
`endif
    .level(b_lv));

  smoldvi_stream_gearbox #(.W_IN(10), .W_OUT(4), .N_CH(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in), .in_valid(c_iv), .in_ready(c_ir),
    .out_data(c_od), .out_valid(c_ov), .out_ready(c_or),
`ifdef SMOLDVI_GEARBOX_BITSLIP_EN
    .bitslip(1'b0),
`endif
    .level(c_lv));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  // One lane-triple word and the five 2-bit chunks (all lanes packed) it must produce.
  typedef struct {
    logic [29:0]     din;
    logic [4:0][5:0] exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int wi, ri, ml;
    // {lane2, lane1, lane0}; chunk i of out_data is {l2[2i+1:2i], l1[..], l0[..]}
    tbl[0].din = {10'h000, 10'h155, 10'h3FF}; tbl[0].exp = {5{6'h07}};
    tbl[1].din = {10'h3FF, 10'h000, 10'h155}; tbl[1].exp = {5{6'h31}};
    tbl[2].din = {10'h155, 10'h3FF, 10'h000}; tbl[2].exp = {5{6'h1C}};
    tbl[3].din = {10'h000, 10'h155, 10'h3FF}; tbl[3].exp = {5{6'h07}};
    tbl[4].din = {10'h3FF, 10'h0E4, 10'h2C6}; tbl[4].exp = {6'h32, 6'h3F, 6'h38, 6'h35, 6'h32};
    tbl[5].din = {10'h3FF, 10'h000, 10'h155}; tbl[5].exp = {5{6'h31}};

    rst = 1'b1;
    a_in = '0; a_iv = 0; a_or = 0; a_bs = 0;
    b_in = '0; b_iv = 0; b_or = 0;
    c_in = '0; c_iv = 0; c_or = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_level", a_lv, 0);
    chk("rst_a_ov", a_ov, 0);
    chk("rst_a_ir", a_ir, 0);
    chk("rst_a_od", a_od, 0);
    chk("rst_b_level", b_lv, 0);
    chk("rst_c_ir", c_ir, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ir", a_ir, 1);
    chk("post_rst_a_ov", a_ov, 0);
    chk("post_rst_b_ir", b_ir, 1);
    chk("post_rst_c_ir", c_ir, 1);

    // A: streaming table, in_valid/out_ready held, level checked against bit count
    wi = 0; ri = 0; a_or = 1;
    for (int cyc = 0; cyc < 200 && ri < 30; cyc++) begin
      @(negedge clk);
      a_iv = (wi < 6);
      a_in = (wi < 6) ? tbl[wi].din : '0;
      #1;
      ml = 10*wi - 2*ri;
      chk("A_level", a_lv, ml);
      chk("A_valid", a_ov, ml >= 2);
      chk("A_ready", a_ir, ml <= 14);
      if (a_ov && a_or) begin
        chk("A_data", a_od, tbl[ri/5].exp[ri%5]);
        ri++;
      end
      if (a_iv && a_ir) wi++;
    end
    if (ri < 30) begin
      n_cmp++; n_err++;
      $display("FAIL A_timeout: got %0d chunks, expected 30", ri);
    end

    // D: backpressure fills to 20, then drains in order
    @(negedge clk);
    a_or = 0; a_iv = 1; a_in = tbl[4].din;
    @(negedge clk);
    a_in = tbl[0].din;
    #1;
    chk("D_level10", a_lv, 10);
    chk("D_ready10", a_ir, 1);
    @(negedge clk);
    #1;
    chk("D_level20", a_lv, 20);
    chk("D_ready20", a_ir, 0);
    chk("D_valid20", a_ov, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("D_hold_level", a_lv, 20);
      chk("D_hold_ready", a_ir, 0);
    end
    @(negedge clk);
    a_iv = 0; a_or = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("D_drain_data", a_od, (i < 5) ? tbl[4].exp[i] : tbl[0].exp[i-5]);
      chk("D_drain_level", a_lv, 20 - 2*i);
      @(negedge clk);
    end
    #1;
    chk("D_empty_level", a_lv, 0);
    chk("D_empty_valid", a_ov, 0);

    // E: reset while streaming, then a clean word comes through untouched
    @(negedge clk);
    a_iv = 1; a_in = tbl[0].din;
    repeat (3) @(negedge clk);
    #1;
    chk("E_pre_level", a_lv, 16);
    rst = 1'b1;
    #1;
    chk("E_rst_ready", a_ir, 0);
    @(negedge clk);
    rst = 1'b0; a_in = tbl[1].din;
    #1;
    chk("E_level", a_lv, 0);
    chk("E_valid", a_ov, 0);
    chk("E_data", a_od, 0);
    chk("E_ready", a_ir, 1);
    @(negedge clk);
    a_iv = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("E_stream_data", a_od, 6'h31);
      chk("E_stream_level", a_lv, 10 - 2*i);
      @(negedge clk);
    end
    #1;
    chk("E_final_level", a_lv, 0);

`ifdef SMOLDVI_GEARBOX_BITSLIP_EN
    // bitslip: leave 4'b1011 per lane, slip once, then slip on an empty buffer
    a_or = 0; a_iv = 1; a_in = {3{10'h2C0}};
    @(negedge clk);
    a_iv = 0;
    #1;
    chk("S_level10", a_lv, 10);
    a_or = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("S_level4", a_lv, 4);
    a_bs = 1;
    #1;
    chk("S_valid_blocked", a_ov, 0);
    @(negedge clk);
    a_bs = 0;
    #1;
    chk("S_level3", a_lv, 3);
    chk("S_valid3", a_ov, 1);
    chk("S_data", a_od, 6'h15);
    @(negedge clk);
    #1;
    chk("S_level1", a_lv, 1);
    a_bs = 1;
    @(negedge clk);
    #1;
    chk("S_level0", a_lv, 0);
    @(negedge clk);
    #1;
    chk("S_empty_slip", a_lv, 0);
    a_bs = 0;
`endif

    // B: 2 -> 10, five pushes of 2'b01 make one word 10'h155
    @(negedge clk);
    b_or = 1; b_iv = 1; b_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("B_level", b_lv, 2*(i+1));
      chk("B_valid", b_ov, 0);
      chk("B_ready", b_ir, 1);
    end
    @(negedge clk);
    b_iv = 0;
    #1;
    chk("B_word_valid", b_ov, 1);
    chk("B_word_data", b_od, 10'h155);
    chk("B_word_level", b_lv, 10);
    @(negedge clk);
    #1;
    chk("B_after_level", b_lv, 0);
    chk("B_after_valid", b_ov, 0);

    // C: 10 -> 4 with carry-over of the 2 leftover bits into the next word
    c_or = 1; c_iv = 1; c_in = 10'h3A5;
    @(negedge clk);
    c_iv = 0;
    #1;
    chk("C_pop0", c_od, 4'h5);
    chk("C_level10", c_lv, 10);
    @(negedge clk);
    #1;
    chk("C_pop1", c_od, 4'hA);
    @(negedge clk);
    #1;
    chk("C_residual_level", c_lv, 2);
    chk("C_residual_valid", c_ov, 0);
    c_iv = 1; c_in = 10'h0F0;
    @(negedge clk);
    c_iv = 0;
    #1;
    chk("C_level12", c_lv, 12);
    chk("C_pop2", c_od, 4'h3);
    @(negedge clk);
    #1;
    chk("C_pop3", c_od, 4'hC);
    @(negedge clk);
    #1;
    chk("C_pop4", c_od, 4'h3);
    @(negedge clk);
    #1;
    chk("C_end_level", c_lv, 0);
    chk("C_end_valid", c_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
